// File: rtl/sc_pkg.sv
// Shared stochastic-computing types and defaults for the SNG / SNC datapath.
package sc_pkg;

    localparam int SC_BN_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } snc_state_e;

endpackage

// File: rtl/sc_ones_counter.sv
// Clearable, enabled ones counter; clear wins over an accepted bit in the same cycle.
module sc_ones_counter #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && bit_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts ones over a STREAM_LEN window of valid bits.
//  state   | meaning
//  S_IDLE  | no window open, waiting for start
//  S_COUNT | window open, accepting valid bits
//  S_DONE  | window complete, publish saturated/scaled count
module sn_to_bn
    import sc_pkg::*;
#(
    parameter int BN_WIDTH   = SC_BN_WIDTH,
    parameter int STREAM_LEN = 1 << BN_WIDTH
) (
    input  logic                i_clk_snc,
    input  logic                i_rst_snc,
    input  logic                i_start_snc,
    input  logic                i_stop_snc,
    input  logic                i_sn_bit,
    input  logic                i_sn_vld,
    output logic [BN_WIDTH-1:0] o_x_bn,
    output logic                o_vld_snc,
    output logic                o_busy_snc
);

    localparam int CW    = $clog2(STREAM_LEN) + 1;
    localparam int SHIFT = $clog2(STREAM_LEN) - BN_WIDTH;

    if (STREAM_LEN < (1 << BN_WIDTH)) begin : g_len_too_short
        $error("sn_to_bn: STREAM_LEN must be at least 1<<BN_WIDTH");
    end
    if ((STREAM_LEN < 2) || ((STREAM_LEN & (STREAM_LEN - 1)) != 0)) begin : g_len_not_pow2
        $error("sn_to_bn: STREAM_LEN must be a power of two >= 2");
    end

    snc_state_e          state_q;
    logic [BN_WIDTH-1:0] x_bn_q;
    logic                vld_q;
    logic                busy_q;

    logic [CW-1:0]       ones_cnt;
    logic [CW-1:0]       bit_cnt;
    logic                start_acc;
    logic                bit_acc;
    logic                last_bit;
    logic [BN_WIDTH-1:0] x_sat;

    // stop beats start beats bit; a start clears the window in any state
    assign start_acc = i_start_snc & ~i_stop_snc;
    assign bit_acc   = (state_q == S_COUNT) & i_sn_vld & ~i_start_snc & ~i_stop_snc;
    assign last_bit  = bit_acc & (bit_cnt == CW'(STREAM_LEN - 1));
    assign x_sat     = (ones_cnt == CW'(STREAM_LEN)) ? {BN_WIDTH{1'b1}}
                                                     : BN_WIDTH'(ones_cnt >> SHIFT);

    sc_ones_counter #(.W(CW)) u_ones_cnt (
        .clk_i (i_clk_snc),
        .rst_i (i_rst_snc),
        .clr_i (start_acc),
        .en_i  (bit_acc),
        .bit_i (i_sn_bit),
        .cnt_o (ones_cnt)
    );

    sc_ones_counter #(.W(CW)) u_bit_cnt (
        .clk_i (i_clk_snc),
        .rst_i (i_rst_snc),
        .clr_i (start_acc),
        .en_i  (bit_acc),
        .bit_i (1'b1),
        .cnt_o (bit_cnt)
    );

    always_ff @(posedge i_clk_snc or posedge i_rst_snc) begin
        if (i_rst_snc) begin
            state_q <= S_IDLE;
            x_bn_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        state_q <= S_COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (i_stop_snc) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_bit) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (i_stop_snc) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        x_bn_q  <= x_sat;
                        vld_q   <= 1'b1;
                        state_q <= i_start_snc ? S_COUNT : S_IDLE;
                        busy_q  <= i_start_snc;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_x_bn     = x_bn_q;
    assign o_vld_snc  = vld_q;
    assign o_busy_snc = busy_q;

endmodule

// File: tb/tb_sn_to_bn.sv
// Directed bench for sn_to_bn (BN_WIDTH=4, STREAM_LEN=16) with a bench-side unary SNG model.
module tb_sn_to_bn;

    logic       i_clk_snc;
    logic       i_rst_snc;
    logic       i_start_snc;
    logic       i_stop_snc;
    logic       i_sn_bit;
    logic       i_sn_vld;
    logic [3:0] o_x_bn;
    logic       o_vld_snc;
    logic       o_busy_snc;

    int n_chk;
    int n_pass;

    sn_to_bn #(.BN_WIDTH(4), .STREAM_LEN(16)) dut (
        .i_clk_snc   (i_clk_snc),
        .i_rst_snc   (i_rst_snc),
        .i_start_snc (i_start_snc),
        .i_stop_snc  (i_stop_snc),
        .i_sn_bit    (i_sn_bit),
        .i_sn_vld    (i_sn_vld),
        .o_x_bn      (o_x_bn),
        .o_vld_snc   (o_vld_snc),
        .o_busy_snc  (o_busy_snc)
    );

    initial i_clk_snc = 1'b0;
    always #5 i_clk_snc = ~i_clk_snc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk_snc);
        #1;
    endtask

    // Start a window (start-cycle bit is 1 and valid, which must be ignored), then
    // feed 16 bits, stalling on cycles flagged in stall_mask. lat = cycles from the
    // start edge until o_vld_snc is seen, 0 on timeout.
    task automatic run_window(input logic [15:0] bits, input logic [31:0] stall_mask,
                              output int lat);
        int idx;
        idx = 0;
        lat = 0;
        i_start_snc = 1'b1;
        i_sn_bit    = 1'b1;
        i_sn_vld    = 1'b1;
        tick();
        i_start_snc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 16 && !(c < 32 && stall_mask[c])) begin
                i_sn_vld = 1'b1;
                i_sn_bit = bits[idx];
                idx++;
            end else begin
                i_sn_vld = 1'b0;
                i_sn_bit = 1'b1;
            end
            tick();
            if (o_vld_snc) begin
                lat = c + 1;
                break;
            end
        end
        i_sn_vld = 1'b0;
        i_sn_bit = 1'b0;
    endtask

    initial begin
        int          lat;
        int          vld_seen;
        logic [15:0] pat;

        n_chk       = 0;
        n_pass      = 0;
        i_rst_snc   = 1'b1;
        i_start_snc = 1'b0;
        i_stop_snc  = 1'b0;
        i_sn_bit    = 1'b0;
        i_sn_vld    = 1'b0;
        tick();
        tick();
        i_rst_snc = 1'b0;

        // idle after reset, inputs toggling but no start
        for (int i = 0; i < 20; i++) begin
            i_sn_bit = i[0];
            i_sn_vld = 1'b1;
            tick();
            check("idle_x",    32'(o_x_bn),     32'd0);
            check("idle_vld",  32'(o_vld_snc),  32'd0);
            check("idle_busy", 32'(o_busy_snc), 32'd0);
        end
        i_sn_vld = 1'b0;

        // unary SNG: x ones then zeros
        for (int x = 0; x < 16; x++) begin
            pat = 16'((32'd1 << x) - 32'd1);
            run_window(pat, 32'h0, lat);
            check($sformatf("sweep_lat_x%0d", x), 32'(lat),    32'd17);
            check($sformatf("sweep_val_x%0d", x), 32'(o_x_bn), 32'(x));
            tick();
            check($sformatf("sweep_pulse_x%0d", x), 32'(o_vld_snc), 32'd0);
        end

        run_window(16'hFFFF, 32'h0, lat);
        check("sat_lat", 32'(lat),    32'd17);
        check("sat_val", 32'(o_x_bn), 32'd15);

        run_window(16'hFFFF, 32'h0000_02AA, lat);
        check("stall_lat", 32'(lat),    32'd22);
        check("stall_val", 32'(o_x_bn), 32'd15);

        // abort mid-window: previous result (9) must survive
        run_window(16'h01FF, 32'h0, lat);
        check("pre_stop_val", 32'(o_x_bn), 32'd9);
        tick();
        i_start_snc = 1'b1;
        tick();
        i_start_snc = 1'b0;
        check("stop_busy_open", 32'(o_busy_snc), 32'd1);
        for (int i = 0; i < 8; i++) begin
            i_sn_vld = 1'b1;
            i_sn_bit = ~i[0];
            tick();
        end
        i_sn_vld   = 1'b0;
        i_stop_snc = 1'b1;
        tick();
        i_stop_snc = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 25; i++) begin
            i_sn_vld = 1'b1;
            i_sn_bit = 1'b1;
            tick();
            if (o_vld_snc) vld_seen++;
        end
        i_sn_vld = 1'b0;
        check("stop_no_vld", 32'(vld_seen),   32'd0);
        check("stop_keep_x", 32'(o_x_bn),     32'd9);
        check("stop_busy",   32'(o_busy_snc), 32'd0);

        // restart discards earlier ones
        i_start_snc = 1'b1;
        tick();
        i_start_snc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_sn_vld = 1'b1;
            i_sn_bit = 1'b1;
            tick();
        end
        run_window(16'h0000, 32'h0, lat);
        check("restart_lat", 32'(lat),    32'd17);
        check("restart_val", 32'(o_x_bn), 32'd0);

        // async reset between edges mid-window
        run_window(16'h001F, 32'h0, lat);
        check("pre_rst_val", 32'(o_x_bn), 32'd5);
        i_start_snc = 1'b1;
        tick();
        i_start_snc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_sn_vld = 1'b1;
            i_sn_bit = 1'b1;
            tick();
        end
        #2;
        i_rst_snc = 1'b1;
        #1;
        check("arst_x",    32'(o_x_bn),     32'd0);
        check("arst_vld",  32'(o_vld_snc),  32'd0);
        check("arst_busy", 32'(o_busy_snc), 32'd0);
        i_sn_vld = 1'b0;
        tick();
        tick();
        i_rst_snc = 1'b0;
        tick();
        run_window(16'h07FF, 32'h0, lat);
        check("post_rst_lat", 32'(lat),    32'd17);
        check("post_rst_val", 32'(o_x_bn), 32'd11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
